// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives PC to the instruction RAM, queues returned words in a prefetch FIFO,
// hands them to decode over valid/ready. Optional perf counters enabled by defining IFETCH_PERF_EN.
module instr_fetch_unit #(
  parameter int unsigned     DEPTH     = 2,
  parameter int unsigned     AW        = 8,
  parameter int unsigned     DW        = 16,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [DW-1:0]   HALT_WORD = DW'(16'h0001)
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic [AW-1:0] ADDR,
  input  logic [DW-1:0] Q,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_stall_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_pc;
  logic [AW-1:0]   w_pc_nxt;
  logic [DW-1:0]   r_mem_instr [DEPTH];
  logic [AW-1:0]   r_mem_pc    [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_flush;
  logic            w_unused;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && instr_ready;
  assign w_unused = redirect_pc[0];

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state, push decision and next PC; redirect outranks fetch
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    if (redirect_valid) begin
      w_flush     = 1'b1;
      w_state_nxt = S_RUN;
      w_pc_nxt    = {redirect_pc[AW-1:1], 1'b0};
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (!w_full || w_pop) begin
            w_push = 1'b1;
            if (Q == HALT_WORD) w_state_nxt = S_HALTED;
            else                w_pc_nxt    = r_pc + AW'(2);
          end
        end
        S_HALTED: begin
          w_state_nxt = S_HALTED;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // PC and FIFO pointers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc     <= {RESET_PC[AW-1:1], 1'b0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= Q;
      r_mem_pc[r_wr_ptr]    <= r_pc;
    end
  end

  assign ADDR        = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = w_empty ? '0 : r_mem_instr[r_rd_ptr];
  assign instr_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign halted      = (r_state == S_HALTED);

`ifdef IFETCH_PERF_EN
  logic [15:0] r_perf_fetch;
  logic [15:0] r_perf_stall;

  // Saturating counters; survive redirects, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push && (r_perf_fetch != 16'hFFFF))
        r_perf_fetch <= r_perf_fetch + 16'd1;
      if ((r_state == S_RUN) && w_full && !w_pop && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
